// File: rtl/ui_pkg.sv
// ui_pkg: clock rate, default debounce window and the ui_in channel map,
// shared by the game FSM and ui_debounce.
package ui_pkg;
    localparam int CLK_HZ                  = 20_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 20_000;
    localparam int UI_CH_COUNT             = 8;
    localparam int CH_SW0       = 0;
    localparam int CH_SW1       = 1;
    localparam int CH_SW2       = 2;
    localparam int CH_SW3       = 3;
    localparam int CH_BTN_START = 4;
    localparam int CH_BTN_A     = 5;
    localparam int CH_BTN_B     = 6;
    localparam int CH_BTN_C     = 7;
endpackage

// File: rtl/ui_debounce_ch.sv
// ui_debounce_ch: one input channel - two-flop synchroniser, stable-count debouncer,
// registered rise/fall pulses suppressed while mask is high.
module ui_debounce_ch import ui_pkg::*; #(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic INIT_LEVEL      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic mask,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync2 != level) && (cnt == LAST);

    // Any cycle agreeing with the current level restarts the stable count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= INIT_LEVEL;
            sync2 <= INIT_LEVEL;
            level <= INIT_LEVEL;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cnt   <= (sync2 == level || cnt == LAST) ? '0 : cnt + CW'(1);
            if (accept) level <= sync2;
            rise  <= accept && sync2 && !mask;
            fall  <= accept && !sync2 && !mask;
        end
    end
endmodule

// File: rtl/ui_debounce.sv
// ui_debounce: WIDTH-channel switch/button conditioner with a post-reset settle flag.
// UI_DEBOUNCE_SETTLE_EN enables the settle counter and pulse masking; otherwise settled is tied high.
module ui_debounce import ui_pkg::*; #(
    parameter int               WIDTH           = UI_CH_COUNT,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] INIT_LEVEL      = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             settled
);
    logic mask;

`ifdef UI_DEBOUNCE_SETTLE_EN
    localparam int SCW = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(DEBOUNCE_CYCLES + 1);

    logic [SCW-1:0] settle_cnt;

    // Counts to DEBOUNCE_CYCLES+2 then freezes with settled high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
            settled    <= 1'b0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + SCW'(1);
            settled    <= settle_cnt == SETTLE_LAST;
        end
    end

    assign mask = !settled;
`else
    assign settled = 1'b1;
    assign mask    = 1'b0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        ui_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INIT_LEVEL     (INIT_LEVEL[i])
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_in[i]),
            .mask (mask),
            .level(level_out[i]),
            .rise (rise_pulse[i]),
            .fall (fall_pulse[i])
        );
    end
endmodule

// File: doc/ui_debounce.md
# ui_debounce

Input conditioner for the board's switches and buttons, sitting directly upstream of the game state machine on `ui_in`. Each channel is synchronised into `clk` and debounced, and one-cycle rise/fall pulses are generated. A `settled` flag holds the game FSM off until the inputs have been stable since reset. This stops a floating or bouncing DIP switch from reading as "on" at power-up and skipping the START state.

## Interface
- `WIDTH`, 8: number of input channels.
- `DEBOUNCE_CYCLES`, 20_000 (1 ms at 20 MHz): consecutive stable cycles required to accept a new level; must be ≥ 2.
- `INIT_LEVEL`, `'0`: per-channel reset value of synchroniser and level registers.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high.
- `raw_in` input WIDTH: asynchronous switch/button inputs.
- `level_out` output WIDTH: debounced level.
- `rise_pulse` output WIDTH: one-cycle pulse when `level_out[i]` goes 0→1.
- `fall_pulse` output WIDTH: one-cycle pulse when `level_out[i]` goes 1→0.
- `settled` output 1: high once the post-reset settle window has elapsed; stays high until the next reset.

## Operation
- **Synchroniser:** two flops per channel (`sync1`, `sync2`); `sync2` is the only value the debouncer sees.
- **Per-channel debouncer:** counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`, plus a `level` register.
  - `sync2 == level`: `cnt <= 0`.
  - `sync2 != level` and `cnt != DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `sync2 != level` and `cnt == DEBOUNCE_CYCLES-1`: `level <= sync2`, `cnt <= 0`, and the matching pulse is registered high for one cycle.
- **Bounce:** any single cycle with `sync2 == level` restarts the count from 0. A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `level_out`.
- **Channel independence:** channels run independently. Several channels may pulse in the same cycle.
- **Pulse exclusivity:** `rise_pulse[i]` and `fall_pulse[i]` are never high together. A channel cannot pulse on consecutive cycles; the minimum spacing is `DEBOUNCE_CYCLES` cycles.
- **Settle counter:** a global counter starts at 0 on reset and increments each cycle. When it reaches `DEBOUNCE_CYCLES+2`, `settled` goes to 1 and the counter stops (holds).
- **Pulse masking:** while `settled == 0`, `level_out` updates normally but pulses are masked. A masked edge is dropped, not deferred.
- **Reset values (applied asynchronously):**
  - `sync1`, `sync2`, `level_out` = `INIT_LEVEL`.
  - All `cnt` = 0.
  - `rise_pulse`, `fall_pulse` = 0.
  - `settled` = 0.
- **Reset mid-operation:** all state returns to reset values immediately. In-progress counts are lost, and no pulse is emitted on entry to or exit from reset.

## Timing
- Let `raw_in[i]` change before edge k and stay stable.
  - `sync2` shows the new value after edge k+1.
  - `level_out[i]` and the pulse change after edge k+1+`DEBOUNCE_CYCLES`.
  - Total latency is `DEBOUNCE_CYCLES+2` edges.
- Pulses are registered, high for exactly one cycle, and coincident with the first cycle of the new `level_out`.
- `settled` rises after edge `DEBOUNCE_CYCLES+2` following reset deassertion.
- All outputs are registered; there are no combinational paths from `raw_in`.

## Configuration
- **Macro:** `UI_DEBOUNCE_SETTLE_EN`.
- **Defined:** settle counter present; `settled` and pulse masking behave as described in Operation.
- **Undefined:**
  - No settle counter.
  - `settled` is a constant 1, including during reset.
  - Pulses are never masked.
  - Latency and all other behaviour are unchanged.

## Structure
- **Shared package `ui_pkg`:** `CLK_HZ = 20_000_000`, `DEFAULT_DEBOUNCE_CYCLES = 20_000`, and the channel index constants for the DIP switches and buttons. The game FSM and `ui_debounce` both import these.
- **Sub-module `ui_debounce_ch`:** one channel (sync, counter, level, pulses, with a mask input), instantiated `WIDTH` times by a generate loop.
- **Top level:** holds the settle counter and the instance array.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `INIT_LEVEL=0`, macro defined unless stated.
- **Reset:** assert `reset` mid-cycle → all outputs 0 asynchronously; deassert → `settled` = 0 for 6 edges, then 1.
- **Clean rise:** after settled, set `raw_in[0]=1` before edge k → `level_out[0]=1` and `rise_pulse[0]=1` after edge k+5; pulse is 0 after edge k+6.
- **Bounce:** `raw_in[1]` toggles 1,0,1,0 on successive cycles, then holds 1 → no output change until 4 stable cycles are counted from the final 1. Exactly one `rise_pulse[1]`.
- **Masked start:** hold `raw_in[0]=1` through reset deassert → `level_out[0]=1` after edge 6. `rise_pulse[0]` never fires; `settled` rises. With the macro undefined, the same stimulus → `rise_pulse[0]` fires at edge 6.
- **Simultaneous edges:** `raw_in` 8'h00→8'hFF in one cycle → `rise_pulse == 8'hFF` for one cycle. Returning to 8'h00 → `fall_pulse == 8'hFF` for one cycle after `DEBOUNCE_CYCLES+2` edges.
- **Reset mid-count:** `raw_in[2]=1` for 3 cycles, then assert `reset` → `level_out[2]=0` with no pulse. After release, with `raw_in[2]` still 1 → level rises 6 edges later, with the pulse masked.
